// File: rtl/mac_seq_pkg.sv
// Shared types and elaboration helpers for the systolic MAC chain sequencer.
package mac_seq_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} seq_state_t;

  localparam int ACC_W = 24;

  function automatic int beat_cnt_w(input int k);
    return $clog2(k + 1);
  endfunction

  function automatic int drain_cnt_w(input int rows);
    return $clog2(rows + 2);
  endfunction

  function automatic longint max_result(input int k, input int dw);
    longint m;
    m = (longint'(1) << dw) - 1;
    return longint'(k) * m * m;
  endfunction

endpackage

// File: rtl/mac_skew_line.sv
// DEPTH-stage zero-reset delay line used to skew one lane's A operand.
module mac_skew_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_shift
    logic [DW-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
        sr_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/mac_array_seq.sv
// Sequencer feeding a ROWS-lane systolic MAC chain: clear, K skewed beats, drain, done.
module mac_array_seq
  import mac_seq_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int K    = 8,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [ROWS*DW-1:0] src_a,
  input  logic [DW-1:0]      src_b,
  output logic               mac_clr,
  output logic               mac_en,
  output logic [DW-1:0]      mac_b,
  output logic [ROWS*DW-1:0] mac_a
);

  localparam int BW = beat_cnt_w(K);
  localparam int CW = drain_cnt_w(ROWS);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(K - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(ROWS);

  if (max_result(K, DW) >= (longint'(1) << ACC_W)) begin : g_width_chk
    $error("mac_array_seq: K*(2^DW-1)^2 does not fit the %0d-bit accumulator", ACC_W);
  end

  seq_state_t    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [CW-1:0] drain_q, drain_d;
  logic          accept;

  assign src_ready = (state_q == FEED);
  assign accept    = src_valid & src_ready;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  // DRAIN lasts ROWS+1 cycles: ROWS-1 skew hops plus the two MAC stages.
  always_comb begin
    state_d = state_q;
    beat_d  = '0;
    drain_d = '0;
    case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: state_d = FEED;
      FEED: begin
        beat_d = beat_q;
        if (accept) begin
          if (beat_q == BEAT_LAST) state_d = DRAIN;
          else                     beat_d  = beat_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic               clr_q, en_q;
  logic [DW-1:0]      b_q;
  logic [ROWS*DW-1:0] a_p0_q;

  // Stage 0: a cycle without an accept launches an all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_q  <= 1'b0;
      en_q   <= 1'b0;
      b_q    <= '0;
      a_p0_q <= '0;
    end else begin
      clr_q  <= (state_d == CLEAR);
      en_q   <= accept;
      b_q    <= accept ? src_b : '0;
      a_p0_q <= accept ? src_a : '0;
    end
  end

  assign mac_clr = clr_q;
  assign mac_en  = en_q;
  assign mac_b   = b_q;

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    mac_skew_line #(
      .DEPTH (i),
      .DW    (DW)
    ) u_skew (
      .clk (clk),
      .rst (rst),
      .d   (a_p0_q[i*DW +: DW]),
      .q   (mac_a[i*DW +: DW])
    );
  end

endmodule
